// File: rtl/alu_slice_mul.sv
// Single-slice 2901-style ALU datapath with register file, Q register and an
// iterative unsigned shift-and-add multiply sequencer (start/busy/done).
module alu_slice_mul #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  din,
    input  logic [ADDR_W-1:0] a_sel,
    input  logic [ADDR_W-1:0] b_sel,
    input  logic [2:0]        alu_src,
    input  logic [2:0]        alu_op,
    input  logic [2:0]        alu_dest,
    input  logic              cin,
    input  logic              ram_lsb_in,
    input  logic              ram_msb_in,
    input  logic              q_lsb_in,
    input  logic              q_msb_in,
    input  logic              start,
    output logic [WIDTH-1:0]  yout,
    output logic              cout,
    output logic              fzero,
    output logic              fmsb,
    output logic              ovr,
    output logic              ram_lsb_out,
    output logic              ram_msb_out,
    output logic              q_lsb_out,
    output logic              q_msb_out,
    output logic              busy,
    output logic              done
);

    localparam int NREGS = 1 << ADDR_W;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    logic [WIDTH-1:0]  regs_q [NREGS];
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_t            state_q, state_d;
    logic              done_q, done_d;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [WIDTH-1:0]  rf_wdata;

    logic [WIDTH-1:0]  a_val, b_val;
    logic [WIDTH-1:0]  r_opd, s_opd;
    logic [WIDTH+1:0]  alu_res;
    logic [WIDTH-1:0]  f_val;
    logic              f_cout, f_ovr;
    logic [WIDTH:0]    mul_sum;

    // Returns {ovr, cout, F}; the carry into the MSB comes from a WIDTH-1 bit add.
    function automatic logic [WIDTH+1:0] alu_eval(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] r,
        input logic [WIDTH-1:0] s,
        input logic             c
    );
        logic [WIDTH-1:0] x, y, low, f;
        logic [WIDTH:0]   sum;
        logic             co, ov;
        x  = r;
        y  = s;
        f  = '0;
        co = 1'b0;
        ov = 1'b0;
        case (op)
            3'd1:    begin x = s; y = ~r; end
            3'd2:    begin x = r; y = ~s; end
            default: begin x = r; y = s;  end
        endcase
        sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        low = {1'b0, x[WIDTH-2:0]} + {1'b0, y[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, c};
        case (op)
            3'd0, 3'd1, 3'd2: begin
                f  = sum[WIDTH-1:0];
                co = sum[WIDTH];
                ov = low[WIDTH-1] ^ sum[WIDTH];
            end
            3'd3:    f = r | s;
            3'd4:    f = r & s;
            3'd5:    f = ~r & s;
            3'd6:    f = r ^ s;
            default: f = ~(r ^ s);
        endcase
        return {ov, co, f};
    endfunction

    function automatic logic [WIDTH-1:0] shr_fill(input logic [WIDTH-1:0] v, input logic fill);
        return {fill, v[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] shl_fill(input logic [WIDTH-1:0] v, input logic fill);
        return {v[WIDTH-2:0], fill};
    endfunction

    assign a_val = regs_q[a_sel];
    assign b_val = regs_q[b_sel];

    always_comb begin
        r_opd = '0;
        s_opd = '0;
        case (alu_src)
            3'd0:    begin r_opd = a_val; s_opd = q_q;   end
            3'd1:    begin r_opd = a_val; s_opd = b_val; end
            3'd2:    begin r_opd = '0;    s_opd = q_q;   end
            3'd3:    begin r_opd = '0;    s_opd = b_val; end
            3'd4:    begin r_opd = '0;    s_opd = a_val; end
            3'd5:    begin r_opd = din;   s_opd = a_val; end
            3'd6:    begin r_opd = din;   s_opd = q_q;   end
            default: begin r_opd = din;   s_opd = '0;    end
        endcase
    end

    assign alu_res = alu_eval(alu_op, r_opd, s_opd, cin);
    assign f_val   = alu_res[WIDTH-1:0];
    assign f_cout  = alu_res[WIDTH];
    assign f_ovr   = alu_res[WIDTH+1];

    assign mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign yout        = busy ? acc_q : ((alu_dest == 3'd2) ? a_val : f_val);
    assign cout        = busy ? 1'b0 : f_cout;
    assign ovr         = busy ? 1'b0 : f_ovr;
    assign fzero       = busy ? 1'b0 : (f_val == '0);
    assign fmsb        = busy ? 1'b0 : f_val[WIDTH-1];
    assign ram_lsb_out = f_val[0];
    assign ram_msb_out = f_val[WIDTH-1];
    assign q_lsb_out   = q_q[0];
    assign q_msb_out   = q_q[WIDTH-1];

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        acc_d    = acc_q;
        m_d      = m_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = b_sel;
        rf_wdata = f_val;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Multiplicand and destination are frozen here; a_sel/b_sel may move on.
                    m_d     = a_val;
                    idx_d   = b_sel;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end else begin
                    case (alu_dest)
                        3'd0: q_d = f_val;
                        3'd1: ;
                        3'd2, 3'd3: rf_we = 1'b1;
                        3'd4: begin
                            rf_we    = 1'b1;
                            rf_wdata = shr_fill(f_val, ram_msb_in);
                            q_d      = shr_fill(q_q, q_msb_in);
                        end
                        3'd5: begin
                            rf_we    = 1'b1;
                            rf_wdata = shr_fill(f_val, ram_msb_in);
                        end
                        3'd6: begin
                            rf_we    = 1'b1;
                            rf_wdata = shl_fill(f_val, ram_lsb_in);
                            q_d      = shl_fill(q_q, q_lsb_in);
                        end
                        default: begin
                            rf_we    = 1'b1;
                            rf_wdata = shl_fill(f_val, ram_lsb_in);
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_sum[WIDTH:1];
                q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = idx_q;
                rf_wdata = acc_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (rf_we) begin
                regs_q[rf_waddr] <= rf_wdata;
            end
        end
    end

endmodule

// File: tb/tb_alu_slice_mul.sv
// Randomized bench for alu_slice_mul against an arithmetic reference model
// (register file array, Q value, product computed by plain multiplication).
module tb_alu_slice_mul;

    localparam int W  = 16;
    localparam int AW = 4;
    localparam int NR = 1 << AW;
    localparam longint unsigned MASK = (64'd1 << W) - 1;

    logic          clock, reset;
    logic [W-1:0]  din;
    logic [AW-1:0] a_sel, b_sel;
    logic [2:0]    alu_src, alu_op, alu_dest;
    logic          cin, ram_lsb_in, ram_msb_in, q_lsb_in, q_msb_in, start;
    logic [W-1:0]  yout;
    logic          cout, fzero, fmsb, ovr;
    logic          ram_lsb_out, ram_msb_out, q_lsb_out, q_msb_out, busy, done;

    alu_slice_mul #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .din(din), .a_sel(a_sel), .b_sel(b_sel),
        .alu_src(alu_src), .alu_op(alu_op), .alu_dest(alu_dest), .cin(cin),
        .ram_lsb_in(ram_lsb_in), .ram_msb_in(ram_msb_in),
        .q_lsb_in(q_lsb_in), .q_msb_in(q_msb_in), .start(start),
        .yout(yout), .cout(cout), .fzero(fzero), .fmsb(fmsb), .ovr(ovr),
        .ram_lsb_out(ram_lsb_out), .ram_msb_out(ram_msb_out),
        .q_lsb_out(q_lsb_out), .q_msb_out(q_msb_out), .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    longint unsigned rm [NR];
    longint unsigned qm;
    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] last_y;
    logic         last_cout, last_ovr, last_fmsb;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input longint unsigned v);
        return (v >= (64'd1 << (W - 1))) ? longint'(v) - (longint'(1) << W) : longint'(v);
    endfunction

    task automatic model_alu(input logic [2:0] src, input logic [2:0] op, input bit c,
                             input longint unsigned a, input longint unsigned b,
                             input longint unsigned d, output longint unsigned f,
                             output bit co, output bit ov);
        longint unsigned r, s, x, y, sum;
        longint t;
        case (src)
            3'd0: begin r = a; s = qm; end
            3'd1: begin r = a; s = b;  end
            3'd2: begin r = 0; s = qm; end
            3'd3: begin r = 0; s = b;  end
            3'd4: begin r = 0; s = a;  end
            3'd5: begin r = d; s = a;  end
            3'd6: begin r = d; s = qm; end
            default: begin r = d; s = 0; end
        endcase
        co = 0;
        ov = 0;
        if (op <= 3'd2) begin
            x = (op == 3'd1) ? s : r;
            y = (op == 3'd0) ? s : (op == 3'd1) ? (~r & MASK) : (~s & MASK);
            sum = x + y + longint'(c);
            f   = sum & MASK;
            co  = (sum >> W) != 0;
            t   = sx(x) + sx(y) + longint'(c);
            ov  = (t > (longint'(1) << (W - 1)) - 1) || (t < -(longint'(1) << (W - 1)));
        end else begin
            case (op)
                3'd3: f = r | s;
                3'd4: f = r & s;
                3'd5: f = ~r & s & MASK;
                3'd6: f = r ^ s;
                default: f = ~(r ^ s) & MASK;
            endcase
        end
    endtask

    task automatic uop(input logic [2:0] src, input logic [2:0] op, input logic [2:0] dest,
                       input bit c, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [W-1:0] d, input bit rli, input bit rmi,
                       input bit qli, input bit qmi);
        longint unsigned f, exp_y;
        bit co, ov;
        start = 0; alu_src = src; alu_op = op; alu_dest = dest; cin = c;
        a_sel = a; b_sel = b; din = d;
        ram_lsb_in = rli; ram_msb_in = rmi; q_lsb_in = qli; q_msb_in = qmi;
        #2;
        model_alu(src, op, c, rm[a], rm[b], longint'(d), f, co, ov);
        exp_y = (dest == 3'd2) ? rm[a] : f;
        chk("uop_y", yout, exp_y);
        chk("uop_flags", {cout, ovr, fzero, fmsb}, {co, ov, f == 0, f[W-1]});
        chk("uop_shio", {ram_lsb_out, ram_msb_out, q_lsb_out, q_msb_out},
            {f[0], f[W-1], qm[0], qm[W-1]});
        chk("uop_busy_done", {busy, done}, 2'b00);
        last_y = yout; last_cout = cout; last_ovr = ovr; last_fmsb = fmsb;
        @(posedge clock); #1;
        case (dest)
            3'd0: qm = f;
            3'd2, 3'd3: rm[b] = f;
            3'd4: begin
                rm[b] = (f >> 1) | (longint'(rmi) << (W - 1));
                qm    = (qm >> 1) | (longint'(qmi) << (W - 1));
            end
            3'd5: rm[b] = (f >> 1) | (longint'(rmi) << (W - 1));
            3'd6: begin
                rm[b] = ((f << 1) | longint'(rli)) & MASK;
                qm    = ((qm << 1) | longint'(qli)) & MASK;
            end
            3'd7: rm[b] = ((f << 1) | longint'(rli)) & MASK;
            default: ;
        endcase
    endtask

    task automatic write_reg(input logic [AW-1:0] b, input logic [W-1:0] v);
        uop(3'd7, 3'd3, 3'd3, 0, '0, b, v, 0, 0, 0, 0);
    endtask

    task automatic write_q(input logic [W-1:0] v);
        uop(3'd7, 3'd3, 3'd0, 0, '0, '0, v, 0, 0, 0, 0);
    endtask

    task automatic expect_reg(input string tag, input logic [AW-1:0] a, input logic [W-1:0] v);
        start = 0; alu_src = 3'd4; alu_op = 3'd3; alu_dest = 3'd1; cin = 0; a_sel = a;
        #2;
        chk(tag, yout, v);
        @(posedge clock); #1;
    endtask

    task automatic expect_q(input string tag, input logic [W-1:0] v);
        start = 0; alu_src = 3'd2; alu_op = 3'd3; alu_dest = 3'd1; cin = 0;
        #2;
        chk(tag, yout, v);
        @(posedge clock); #1;
    endtask

    task automatic rand_inputs();
        din = W'($urandom); a_sel = AW'($urandom); b_sel = AW'($urandom);
        alu_src = 3'($urandom); alu_op = 3'($urandom); alu_dest = 3'($urandom);
        cin = 1'($urandom); ram_lsb_in = 1'($urandom); ram_msb_in = 1'($urandom);
        q_lsb_in = 1'($urandom); q_msb_in = 1'($urandom);
    endtask

    task automatic do_mul(input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input bit fixed_busy, input bit b2b);
        longint unsigned mm, q0, prod, part;
        logic [AW-1:0] idx;
        start = 1; a_sel = a; b_sel = b; alu_src = 3'd7; alu_op = 3'd3; alu_dest = 3'd3;
        din = W'($urandom);
        @(posedge clock); #1;
        mm = rm[a]; q0 = qm; idx = b;
        for (int k = 0; k <= W; k++) begin
            part = (mm * (q0 & ((64'd1 << k) - 1))) >> k;
            chk("mul_busy_done", {busy, done}, 2'b10);
            chk("mul_acc", yout, part);
            chk("mul_flags", {cout, ovr, fzero, fmsb}, 4'b0000);
            if (fixed_busy) begin
                start = 1; alu_src = 3'd7; alu_op = 3'd3; alu_dest = 3'd3;
                b_sel = 4'd7; din = 16'h5555; a_sel = 4'd0;
            end else begin
                rand_inputs();
                start = 1'($urandom);
            end
            @(posedge clock); #1;
        end
        prod  = mm * q0;
        rm[idx] = prod >> W;
        qm    = prod & MASK;
        chk("mul_end_busy_done", {busy, done}, 2'b01);
        if (!b2b) begin
            start = 0; alu_dest = 3'd1;
            @(posedge clock); #1;
            chk("mul_done_clear", {busy, done}, 2'b00);
        end
    endtask

    task automatic reset_mid(input logic [AW-1:0] a, input logic [AW-1:0] b);
        start = 1; a_sel = a; b_sel = b; alu_dest = 3'd1;
        @(posedge clock); #1;
        start = 0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clock); #1;
        end
        reset = 1;
        @(posedge clock); #1;
        chk("rst_mid_busy_done", {busy, done}, 2'b00);
        reset = 0;
        for (int i = 0; i < NR; i++) rm[i] = 0;
        qm = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; start = 0; din = '0; a_sel = '0; b_sel = '0;
        alu_src = 3'd1; alu_op = 3'd0; alu_dest = 3'd1; cin = 0;
        ram_lsb_in = 0; ram_msb_in = 0; q_lsb_in = 0; q_msb_in = 0;
        for (int i = 0; i < NR; i++) rm[i] = 0;
        qm = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_busy_done", {busy, done}, 2'b00);
        reset = 0;
        expect_reg("reset_r5", 4'd5, 16'h0000);
        expect_q("reset_q", 16'h0000);

        // Signed overflow into the MSB
        write_reg(4'd1, 16'h7FFF);
        write_reg(4'd2, 16'h0001);
        uop(3'd1, 3'd0, 3'd3, 0, 4'd1, 4'd2, '0, 0, 0, 0, 0);
        chk("t1_y", last_y, 16'h8000);
        chk("t1_flags", {last_ovr, last_cout, last_fmsb}, 3'b101);
        expect_reg("t1_r2", 4'd2, 16'h8000);

        // R + ~0 + 1 then a right shift of F and Q
        uop(3'd7, 3'd2, 3'd0, 1, '0, '0, 16'h0005, 0, 0, 0, 0);
        chk("t2_f", last_y, 16'h0005);
        chk("t2_cout", last_cout, 1'b1);
        expect_q("t2_q", 16'h0005);
        uop(3'd2, 3'd0, 3'd4, 0, '0, 4'd6, '0, 0, 0, 0, 1);
        expect_q("t2_qshift", 16'h8002);
        expect_reg("t2_rshift", 4'd6, 16'h0002);

        // 0xFFFF * 0xFFFF
        write_reg(4'd3, 16'hFFFF);
        write_q(16'hFFFF);
        do_mul(4'd3, 4'd4, 0, 0);
        expect_reg("t3_hi", 4'd4, 16'hFFFE);
        expect_q("t3_lo", 16'h0001);

        // Zero multiplier, with start and writes hammered while busy
        write_reg(4'd5, 16'h1234);
        write_reg(4'd7, 16'hABCD);
        write_reg(4'd8, 16'h9999);
        write_q(16'h0000);
        do_mul(4'd5, 4'd8, 1, 0);
        expect_reg("t4_hi", 4'd8, 16'h0000);
        expect_reg("t4_keep", 4'd7, 16'hABCD);
        expect_q("t4_lo", 16'h0000);

        // Reset during the multiply
        write_q(16'h00FF);
        write_reg(4'd9, 16'h3333);
        reset_mid(4'd9, 4'd10);
        expect_reg("t5_dest", 4'd10, 16'h0000);
        expect_q("t5_q", 16'h0000);

        // Back-to-back: second start on the done cycle
        write_reg(4'd1, 16'h0003);
        write_q(16'h0005);
        do_mul(4'd1, 4'd2, 0, 1);
        do_mul(4'd1, 4'd3, 0, 0);
        expect_reg("t6_hi", 4'd3, 16'h0000);
        expect_q("t6_lo", 16'h002D);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    do_mul(AW'($urandom), AW'($urandom), 0, 1);
                end
                do_mul(AW'($urandom), AW'($urandom), 0, 0);
            end else begin
                uop(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                    AW'($urandom), AW'($urandom), W'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
